// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for braun_multiplier and its downstream product_accumulator.
//   PROD_W      : width of a multiplier product (8)
//   OP_W        : width of a multiplier operand (4)
//   acc_state_t : accumulator FSM states {ACC, OUT}
// ----------------------------------------------------------------------------
package mult_pkg;

   localparam int unsigned PROD_W = 8;
   localparam int unsigned OP_W   = 4;

   // ACC: accepting terms, OUT: holding a group result
   typedef enum logic [0:0] {
      ACC = 1'b0,
      OUT = 1'b1
   } acc_state_t;

endpackage : mult_pkg

// File: rtl/product_accumulator_if.sv
// ----------------------------------------------------------------------------
// product_accumulator_if
// Product input stream and group-result output stream of product_accumulator.
//   in_valid/in_ready/in_prod/in_last      : product beat handshake
//   out_valid/out_ready/out_sum/out_count/out_ovf : group result handshake
// Modports:
//   slave  : the accumulator (consumes products, produces results)
//   master : the environment (produces products, consumes results)
// ----------------------------------------------------------------------------
interface product_accumulator_if
   import mult_pkg::*;
#(
   parameter int unsigned ACC_W = 12,
   parameter int unsigned CNT_W = 5
);

   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;

   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_prod,
      input  in_last,
      output out_valid,
      input  out_ready,
      output out_sum,
      output out_count,
      output out_ovf
   );

   modport master (
      output in_valid,
      input  in_ready,
      output in_prod,
      output in_last,
      input  out_valid,
      output out_ready,
      input  out_sum,
      input  out_count,
      input  out_ovf
   );

endinterface : product_accumulator_if

// File: rtl/acc_add_sat.sv
// ----------------------------------------------------------------------------
// acc_add_sat
// ACC_W-wide combinational adder of the running sum and one product.
// Build option: PRODUCT_ACC_SATURATE_EN
//   defined   : sum clamps to all-ones whenever the add carries out
//   undefined : sum wraps modulo 2^ACC_W
// In both builds carry reports the raw carry out of ACC_W.
// Ports:
//   acc    in  ACC_W   running sum
//   addend in  PROD_W  product term
//   sum    out ACC_W   updated sum
//   carry  out 1       carry out of the ACC_W-bit add
// ----------------------------------------------------------------------------
module acc_add_sat
   import mult_pkg::*;
#(
   parameter int unsigned ACC_W = 12
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] addend,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   localparam int unsigned SUM_W = ACC_W + 1;

   logic [SUM_W-1:0] raw;

   assign raw   = {1'b0, acc} + SUM_W'(addend);
   assign carry = raw[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
   // Once clamped, any further non-zero term carries again, so the sum
   // stays all-ones for the rest of the group.
   assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
   assign sum = raw[ACC_W-1:0];
`endif

endmodule : acc_add_sat

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
// Sums a group of 8-bit products (dot-product reduction) and presents the
// group total, term count and sticky overflow flag on a valid/ready port.
// A group closes on a beat with in_last set or on its MAX_TERMS-th beat.
// Build option: PRODUCT_ACC_SATURATE_EN (see acc_add_sat).
// Parameters:
//   ACC_W     accumulator / out_sum width (>= 8)
//   MAX_TERMS forced close after this many terms (>= 1)
//   CNT_W     term counter / out_count width
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of product_accumulator_if
//          (in_valid/in_ready/in_prod/in_last,
//           out_valid/out_ready/out_sum/out_count/out_ovf)
// ----------------------------------------------------------------------------
module product_accumulator
   import mult_pkg::*;
#(
   parameter int unsigned ACC_W     = 12,
   parameter int unsigned MAX_TERMS = 16,
   parameter int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   product_accumulator_if.slave  bus
);

   acc_state_t       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [ACC_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_out_q, ovf_out_d;

   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;
   logic             close;

   // Running sum plus current product
   acc_add_sat #(
      .ACC_W (ACC_W)
   ) u_add (
      .acc    (acc_q),
      .addend (bus.in_prod),
      .sum    (add_sum),
      .carry  (add_carry)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign accept  = bus.in_valid && (state_q == ACC);
   // A beat that is both last and the MAX_TERMS-th closes exactly once
   assign close   = accept && (bus.in_last || (cnt_inc == CNT_W'(MAX_TERMS)));

   // Next-state, datapath and result capture
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      sum_d     = sum_q;
      count_d   = count_q;
      ovf_out_d = ovf_out_q;

      case (state_q)
         ACC: begin
            if (accept) begin
               acc_d = add_sum;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | add_carry;
            end
            if (close) begin
               state_d   = OUT;
               sum_d     = add_sum;
               count_d   = cnt_inc;
               ovf_out_d = ovf_q | add_carry;
            end
         end
         OUT: begin
            // Result registers are left untouched so they hold through stalls
            if (bus.out_ready) begin
               state_d = ACC;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = ACC;
         end
      endcase
   end

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         sum_q     <= '0;
         count_q   <= '0;
         ovf_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         sum_q     <= sum_d;
         count_q   <= count_d;
         ovf_out_q <= ovf_out_d;
      end
   end

   // Handshake flags decode the state register only
   assign bus.in_ready  = (state_q == ACC);
   assign bus.out_valid = (state_q == OUT);
   assign bus.out_sum   = sum_q;
   assign bus.out_count = count_q;
   assign bus.out_ovf   = ovf_out_q;

endmodule : product_accumulator
